dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing the data memory.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NREQ  per-requester access request; held with its attributes until the matching gnt.
REQ-007 we  input  NREQ  per-requester write enable (1 = store, 0 = load).
REQ-008 addr  input  NREQ*AW  per-requester byte address, requester i in slice [i*AW +: AW].
REQ-009 wdata  input  NREQ*DW  per-requester store data, same slicing.
REQ-010 gnt  output  NREQ  one-hot, one-cycle pulse marking the cycle a requester's access reaches memory.
REQ-011 rvalid  output  NREQ  one-hot, one-cycle pulse marking load data valid on rdata.
REQ-012 rdata  output  DW  registered load data, shared by all requesters.
REQ-013 busy  output  1  high while the state is SERVE.
REQ-014 mem_re, mem_we  output  1 each  data-memory read and write strobes.
REQ-015 mem_addr  output  AW; mem_wdata  output  DW  memory address and store data.
REQ-016 mem_rdata  input  DW  combinational read data from memory (valid in the same cycle as mem_re).

Function
REQ-017 The FSM SHALL have two states, IDLE and SERVE, plus registers owner (index) and last (index of the most recent winner).
REQ-018 Eligible set each cycle SHALL be req & ~gnt. In IDLE or SERVE, a non-empty eligible set SHALL select the winner w as the first eligible index scanning from (last+1) mod NREQ upward with wrap-around; at the edge: state<=SERVE, owner<=w, last<=w.
REQ-019 An empty eligible set SHALL move the FSM to IDLE, with owner and last unchanged.
REQ-020 In SERVE the block SHALL assert gnt[owner]=1, drive mem_addr=addr[owner], mem_we=we[owner], mem_re=~we[owner], mem_wdata=wdata[owner]; outside SERVE all mem_* outputs SHALL be 0.
REQ-021 On a SERVE cycle with mem_re=1, rdata SHALL capture mem_rdata, and rvalid[owner] SHALL pulse exactly one cycle later; stores SHALL produce no rvalid, and rdata SHALL hold its value.
REQ-022 Latency SHALL be: req high at cycle t (FSM idle) -> gnt at t+1 -> rvalid at t+2 for loads.
REQ-023 Back-to-back SERVE cycles SHALL be allowed for different requesters; one requester SHALL never be granted on two consecutive cycles (at most 50% bandwidth alone).
REQ-024 rvalid of one access and gnt of the next access MAY coincide and SHALL both be honoured.
REQ-025 A requester dropping req before its gnt SHALL be treated as withdrawn, with no access.
REQ-026 With all NREQ requesting continuously, each SHALL receive exactly one gnt in every NREQ consecutive SERVE cycles.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, owner=0, last=NREQ-1, gnt=0, rvalid=0, rdata=0, busy=0, all mem_*=0.
REQ-028 An access in SERVE when rst rises SHALL be abandoned, with no later rvalid; an in-flight rvalid SHALL be cancelled.
REQ-029 After rst deasserts, requester 0 SHALL have the highest priority for the first arbitration.

Structure
REQ-030 Package riscv_pkg SHALL hold the NREQ/AW/DW defaults and the arb_state_t encoding (IDLE=0, SERVE=1).
REQ-031 Round-robin selection SHALL live in a combinational sub-module rr_pick (inputs: eligible vector, last; outputs: winner, any).

Verification
REQ-032 Reset: rst high mid-SERVE load -> all outputs 0 at once; no rvalid after release.
REQ-033 Single load: req[0]=1, we=0, addr=60, memory word 15 = 65 -> gnt[0] at t+1 with mem_addr=60, mem_re=1; rvalid[0] at t+2, rdata=65.
REQ-034 Store then load: req[1] store of 0xDEADBEEF to addr 68, then load of 68 -> mem_we=1 for one cycle, no rvalid; the load returns 0xDEADBEEF.
REQ-035 Contention: req=2'b11 from reset, both loads (addr 60 and 68) -> gnt order 0 then 1 on consecutive cycles; rvalid[0] rdata=65, then rvalid[1] rdata=56.
REQ-036 Fairness: both requesters reasserting every cycle for 20 cycles -> alternating gnt 0,1,0,1..., with an equal count of 10 each.
REQ-037 Withdrawal: req[1] pulsed for 1 cycle while req[0] is being served -> req[1] is never granted, FSM returns to IDLE, busy=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared defaults and state encoding for the data-memory arbiter.
package riscv_pkg;

  localparam int NREQ_DEF = 2;
  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;

  // Arbiter FSM encoding: IDLE has nothing on the memory port, SERVE owns it.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  // Index width for a requester number; never zero so a 1-requester build still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Round-robin picker: first eligible index after `last`, wrapping around.
module rr_pick
  import riscv_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   winner_o,
  output logic            any_o
);

  assign any_o = |elig_i;

  // Scan offsets from farthest to nearest so the nearest eligible index after `last` wins.
  // The sum of last (< NREQ) and offset (<= NREQ) fits in IW+1 bits, so one subtraction wraps it.
  always_comb begin : scan
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    sum      = '0;
    idx      = '0;
    winner_o = last_i;
    for (int k = NREQ; k >= 1; k--) begin
      sum = {1'b0, last_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      idx = sum[IW-1:0];
      if (elig_i[idx]) begin
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-ported data memory among NREQ requesters.
//
// Handshake: a requester raises req[i] together with we/addr/wdata and holds them
// unchanged until the cycle in which gnt[i] is high; that gnt cycle is the cycle its
// access is presented on the mem_* port. Dropping req before gnt withdraws the request.
// Loads return rdata one cycle after gnt, marked by a one-cycle rvalid[i] pulse.
// A requester is never granted twice in a row, because the gnt bit masks its own req
// out of the next arbitration.
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic             busy,
  output logic             mem_re,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int IW = idx_width(NREQ);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [AW-1:0]     addr_a  [NREQ];
  logic [DW-1:0]     wdata_a [NREQ];
  logic [NREQ-1:0]   elig;
  logic [IW-1:0]     pick_win;
  logic              pick_any;
  logic              serve;
  logic              own_we;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*AW +: AW];
    assign wdata_a[g] = wdata[g*DW +: DW];
  end

  assign serve  = (state_q == SERVE);
  assign own_we = we[owner_q];

  // The requester being served this cycle sits out the next arbitration.
  assign elig = req & ~gnt;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .elig_i   (elig),
    .last_i   (last_q),
    .winner_o (pick_win),
    .any_o    (pick_any)
  );

  // Grant pulse and memory port are a pure function of the registered state and owner.
  always_comb begin
    gnt       = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (serve) begin
      gnt[owner_q] = 1'b1;
      mem_re       = ~own_we;
      mem_we       = own_we;
      mem_addr     = addr_a[owner_q];
      mem_wdata    = wdata_a[owner_q];
    end
  end

  // Next state: arbitrate every cycle; capture load data while a load is on the port.
  always_comb begin
    state_d  = IDLE;
    owner_d  = owner_q;
    last_d   = last_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (pick_any) begin
      state_d = SERVE;
      owner_d = pick_win;
      last_d  = pick_win;
    end
    if (serve && !own_we) begin
      rvalid_d[owner_q] = 1'b1;
      rdata_d           = mem_rdata;
    end
  end

  // State registers; reset leaves last at NREQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IW'(NREQ - 1);
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign busy   = serve;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;
  import riscv_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MEMW = 32;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              busy, mem_re, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Environment memory: combinational read, write on the clock edge.
  logic [DW-1:0] env_mem [MEMW];
  assign mem_rdata = env_mem[mem_addr[6:2]];
  always @(posedge clk) if (mem_we) env_mem[mem_addr[6:2]] <= mem_wdata;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0]   model_mem [MEMW];
  logic [DW-1:0]   exp_q[$];
  logic            m_serve;
  int              m_owner, m_last;
  logic [NREQ-1:0] m_rv;
  logic [DW-1:0]   m_rdata;
  logic [AW-1:0]   a_v [NREQ];
  logic [DW-1:0]   w_v [NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 15) return 32'd65;
    if (i == 17) return 32'd56;
    return 32'h1000 + i;
  endfunction

  task automatic init_mems();
    for (int i = 0; i < MEMW; i++) begin
      env_mem[i]   = init_word(i);
      model_mem[i] = init_word(i);
    end
  endtask

  task automatic drive(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] w);
    rst = r;
    req = rq;
    we  = w;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW]  = a_v[i];
      wdata[i*DW +: DW] = w_v[i];
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] a0, a1, wd1;
    logic [1:0]  g, rv;
    logic [31:0] rd;
    logic        busy, re, wr;
    logic [31:0] maddr, mwd;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] w,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd1,
                              input logic [1:0] g, input logic [1:0] rv, input logic [31:0] rd,
                              input logic b, input logic re, input logic wr,
                              input logic [31:0] ma, input logic [31:0] mwd);
    vec_t v;
    v.rst = r; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.wd1 = wd1;
    v.g = g; v.rv = rv; v.rd = rd; v.busy = b; v.re = re; v.wr = wr;
    v.maddr = ma; v.mwd = mwd;
    return v;
  endfunction

  initial begin
    logic [NREQ-1:0] eg, rq, wv, oh;
    logic            do_rst, found, e_re, e_we;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wd;
    int              win, c0, c1;

    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < NREQ; i++) begin a_v[i] = '0; w_v[i] = '0; end
    init_mems();

    //          rst req   we    a0  a1  wd1           g     rv    rdata         b  re we maddr mwdata
    vecs[0]  = mk(1, 2'b00, 2'b00, 0,  0,  0,            2'b00, 2'b00, 0,            0, 0, 0, 0,  0);
    // single load of word 15
    vecs[1]  = mk(0, 2'b01, 2'b00, 60, 0,  0,            2'b00, 2'b00, 0,            0, 0, 0, 0,  0);
    vecs[2]  = mk(0, 2'b01, 2'b00, 60, 0,  0,            2'b01, 2'b00, 0,            1, 1, 0, 60, 0);
    vecs[3]  = mk(0, 2'b00, 2'b00, 0,  0,  0,            2'b00, 2'b01, 65,           0, 0, 0, 0,  0);
    // requester 1 stores then loads addr 68
    vecs[4]  = mk(0, 2'b10, 2'b10, 0,  68, 32'hDEADBEEF, 2'b00, 2'b00, 65,           0, 0, 0, 0,  0);
    vecs[5]  = mk(0, 2'b10, 2'b10, 0,  68, 32'hDEADBEEF, 2'b10, 2'b00, 65,           1, 0, 1, 68, 32'hDEADBEEF);
    vecs[6]  = mk(0, 2'b10, 2'b00, 0,  68, 0,            2'b00, 2'b00, 65,           0, 0, 0, 0,  0);
    vecs[7]  = mk(0, 2'b10, 2'b00, 0,  68, 0,            2'b10, 2'b00, 65,           1, 1, 0, 68, 0);
    vecs[8]  = mk(0, 2'b00, 2'b00, 0,  0,  0,            2'b00, 2'b10, 32'hDEADBEEF, 0, 0, 0, 0,  0);
    // contention from reset: 0 then 1 back to back, rvalid overlaps the second gnt
    vecs[9]  = mk(1, 2'b00, 2'b00, 0,  0,  0,            2'b00, 2'b00, 0,            0, 0, 0, 0,  0);
    vecs[10] = mk(0, 2'b11, 2'b00, 60, 68, 0,            2'b00, 2'b00, 0,            0, 0, 0, 0,  0);
    vecs[11] = mk(0, 2'b11, 2'b00, 60, 68, 0,            2'b01, 2'b00, 0,            1, 1, 0, 60, 0);
    vecs[12] = mk(0, 2'b10, 2'b00, 60, 68, 0,            2'b10, 2'b01, 65,           1, 1, 0, 68, 0);
    vecs[13] = mk(0, 2'b00, 2'b00, 0,  0,  0,            2'b00, 2'b10, 56,           0, 0, 0, 0,  0);
    // withdrawal: req[1] pulsed one cycle while req[0] is arbitrated and served
    vecs[14] = mk(1, 2'b00, 2'b00, 0,  0,  0,            2'b00, 2'b00, 0,            0, 0, 0, 0,  0);
    vecs[15] = mk(0, 2'b11, 2'b00, 60, 68, 0,            2'b00, 2'b00, 0,            0, 0, 0, 0,  0);
    vecs[16] = mk(0, 2'b01, 2'b00, 60, 68, 0,            2'b01, 2'b00, 0,            1, 1, 0, 60, 0);
    vecs[17] = mk(0, 2'b00, 2'b00, 0,  0,  0,            2'b00, 2'b01, 65,           0, 0, 0, 0,  0);
    vecs[18] = mk(0, 2'b00, 2'b00, 0,  0,  0,            2'b00, 2'b00, 65,           0, 0, 0, 0,  0);

    for (int n = 0; n < NVEC; n++) begin
      @(posedge clk); #1;
      a_v[0] = vecs[n].a0; a_v[1] = vecs[n].a1;
      w_v[0] = '0;         w_v[1] = vecs[n].wd1;
      drive(vecs[n].rst, vecs[n].req, vecs[n].we);
      if (vecs[n].rst) init_mems();
      @(negedge clk);
      check($sformatf("vec%0d_gnt", n),       64'(gnt),       64'(vecs[n].g));
      check($sformatf("vec%0d_rvalid", n),    64'(rvalid),    64'(vecs[n].rv));
      check($sformatf("vec%0d_rdata", n),     64'(rdata),     64'(vecs[n].rd));
      check($sformatf("vec%0d_busy", n),      64'(busy),      64'(vecs[n].busy));
      check($sformatf("vec%0d_mem_re", n),    64'(mem_re),    64'(vecs[n].re));
      check($sformatf("vec%0d_mem_we", n),    64'(mem_we),    64'(vecs[n].wr));
      check($sformatf("vec%0d_mem_addr", n),  64'(mem_addr),  64'(vecs[n].maddr));
      check($sformatf("vec%0d_mem_wdata", n), 64'(mem_wdata), 64'(vecs[n].mwd));
    end

    // ---------------- reset in the middle of a SERVE load ----------------
    @(posedge clk); #1;
    a_v[0] = 60; a_v[1] = 0; w_v[0] = 0; w_v[1] = 0;
    drive(0, 2'b01, 2'b00);
    @(negedge clk);
    check("midrst_pre_gnt", 64'(gnt), 64'(2'b00));
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_serving", 64'(gnt), 64'(2'b01));
    #2 rst = 1'b1;
    #1;
    check("midrst_gnt",    64'(gnt),      64'(0));
    check("midrst_busy",   64'(busy),     64'(0));
    check("midrst_re",     64'(mem_re),   64'(0));
    check("midrst_we",     64'(mem_we),   64'(0));
    check("midrst_addr",   64'(mem_addr), 64'(0));
    check("midrst_rvalid", 64'(rvalid),   64'(0));
    check("midrst_rdata",  64'(rdata),    64'(0));
    @(posedge clk); #1;
    drive(0, 2'b00, 2'b00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("midrst_no_rvalid%0d", c), 64'(rvalid), 64'(0));
      @(posedge clk); #1;
    end

    // ---------------- fairness under continuous contention ----------------
    drive(1, 2'b00, 2'b00);
    @(posedge clk); #1;
    a_v[0] = 60; a_v[1] = 68;
    drive(0, 2'b11, 2'b00);
    c0 = 0; c1 = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c == 0) check("fair_first_idle", 64'(gnt), 64'(2'b00));
      else        check($sformatf("fair_gnt%0d", c), 64'(gnt), 64'((c % 2 == 1) ? 2'b01 : 2'b10));
      if (gnt[0]) c0++;
      if (gnt[1]) c1++;
      @(posedge clk); #1;
    end
    check("fair_count0", 64'(c0), 64'(10));
    check("fair_count1", 64'(c1), 64'(10));

    // ---------------- randomized traffic vs. reference model ----------------
    drive(1, 2'b00, 2'b00);
    init_mems();
    m_serve = 1'b0; m_owner = 0; m_last = NREQ - 1; m_rv = '0; m_rdata = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      do_rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) begin
        rq[i]  = ($urandom_range(0, 3) != 0);
        wv[i]  = $urandom_range(0, 1) != 0;
        a_v[i] = AW'($urandom_range(0, MEMW - 1) * 4);
        w_v[i] = $urandom;
      end
      drive(do_rst, rq, wv);
      if (do_rst) begin
        m_serve = 1'b0; m_owner = 0; m_last = NREQ - 1; m_rv = '0; m_rdata = '0;
        exp_q.delete();
      end
      @(negedge clk);
      eg = '0; e_re = 0; e_we = 0; e_addr = '0; e_wd = '0;
      if (m_serve) begin
        eg[m_owner] = 1'b1;
        e_re   = ~wv[m_owner];
        e_we   = wv[m_owner];
        e_addr = a_v[m_owner];
        e_wd   = w_v[m_owner];
      end
      if (m_rv != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rnd_load_queue: got empty queue expected pending load (cyc %0d)", cyc);
        end else begin
          m_rdata = exp_q.pop_front();
        end
      end
      check($sformatf("rnd%0d_gnt", cyc),       64'(gnt),       64'(eg));
      check($sformatf("rnd%0d_busy", cyc),      64'(busy),      64'(m_serve));
      check($sformatf("rnd%0d_mem_re", cyc),    64'(mem_re),    64'(e_re));
      check($sformatf("rnd%0d_mem_we", cyc),    64'(mem_we),    64'(e_we));
      check($sformatf("rnd%0d_mem_addr", cyc),  64'(mem_addr),  64'(e_addr));
      check($sformatf("rnd%0d_mem_wdata", cyc), 64'(mem_wdata), 64'(e_wd));
      check($sformatf("rnd%0d_rvalid", cyc),    64'(rvalid),    64'(m_rv));
      check($sformatf("rnd%0d_rdata", cyc),     64'(rdata),     64'(m_rdata));
      if (!do_rst) begin
        // the access on the port this cycle
        m_rv = '0;
        if (m_serve) begin
          if (wv[m_owner]) begin
            model_mem[a_v[m_owner][6:2]] = w_v[m_owner];
          end else begin
            exp_q.push_back(model_mem[a_v[m_owner][6:2]]);
            oh = '0; oh[m_owner] = 1'b1;
            m_rv = oh;
          end
        end
        // round-robin choice among requesters not granted this cycle
        found = 1'b0; win = 0;
        for (int k = 1; k <= NREQ; k++) begin
          if (!found && rq[(m_last + k) % NREQ] && !eg[(m_last + k) % NREQ]) begin
            found = 1'b1;
            win   = (m_last + k) % NREQ;
          end
        end
        m_serve = found;
        if (found) begin
          m_owner = win;
          m_last  = win;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
